// File: rtl/ball_locator.sv
// Bright-pixel centroid locator: accumulates qualifying pixel coordinates per frame,
// then divides the sums by the pixel count with a serial restoring divider.
module ball_locator #(
  parameter int unsigned MIN_COUNT = 16,
  parameter int unsigned FRAME_W   = 640,
  parameter int unsigned FRAME_H   = 480
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic [3:0] pix_data,
  input  logic       frame_end,
  input  logic [3:0] threshold,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       changeIdeal,
  output logic       ball_found,
  output logic       busy
);

  localparam int unsigned SUM_W    = 28;
  localparam int unsigned CNT_W    = 19;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned BIT_W    = 5;
  localparam int unsigned DIV_LAST = 27;

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, PUBLISH} state_t;

  state_t             state, next_state;
  logic [SUM_W-1:0]   acc_x, acc_y;
  logic [CNT_W-1:0]   acc_cnt;
  logic [SUM_W-1:0]   snap_y;
  logic [CNT_W-1:0]   divisor;
  logic [SUM_W-1:0]   dividend;
  logic [CNT_W-1:0]   rem;
  logic [BIT_W-1:0]   bit_cnt;
  logic [X_W-1:0]     quo_x;
  logic               found_q;

  logic               pix_qual;
  logic [SUM_W-1:0]   sum_x_tot, sum_y_tot;
  logic [CNT_W-1:0]   cnt_tot;
  logic               meets_min;
  logic               div_done;
  logic [CNT_W:0]     rem_sh;
  logic               q_bit;
  logic [CNT_W-1:0]   rem_next;
  logic [SUM_W-1:0]   div_next;

  // Totals include a pixel arriving in the same cycle as frame_end
  always_comb begin
    pix_qual  = pix_valid && (pix_data >= threshold) &&
                (32'(pix_x) < FRAME_W) && (32'(pix_y) < FRAME_H);
    sum_x_tot = acc_x + (pix_qual ? SUM_W'(pix_x) : '0);
    sum_y_tot = acc_y + (pix_qual ? SUM_W'(pix_y) : '0);
    cnt_tot   = acc_cnt + CNT_W'(pix_qual);
    meets_min = (cnt_tot != '0) && (cnt_tot >= CNT_W'(MIN_COUNT));
    div_done  = (bit_cnt == BIT_W'(DIV_LAST));
  end

  // One restoring-division step: quotient bits shift into the dividend register
  always_comb begin
    rem_sh   = {rem, dividend[SUM_W-1]};
    q_bit    = (rem_sh >= {1'b0, divisor});
    rem_next = q_bit ? CNT_W'(rem_sh - {1'b0, divisor}) : CNT_W'(rem_sh);
    div_next = {dividend[SUM_W-2:0], q_bit};
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_end) next_state = meets_min ? DIV_X : PUBLISH;
      DIV_X:   if (div_done)  next_state = DIV_Y;
      DIV_Y:   if (div_done)  next_state = PUBLISH;
      PUBLISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Accumulators run in every state; any frame_end clears them
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x   <= '0;
      acc_y   <= '0;
      acc_cnt <= '0;
    end else if (frame_end) begin
      acc_x   <= '0;
      acc_y   <= '0;
      acc_cnt <= '0;
    end else begin
      acc_x   <= sum_x_tot;
      acc_y   <= sum_y_tot;
      acc_cnt <= cnt_tot;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_y      <= '0;
      divisor     <= '0;
      dividend    <= '0;
      rem         <= '0;
      bit_cnt     <= '0;
      quo_x       <= '0;
      found_q     <= 1'b0;
      ball_x      <= '0;
      ball_y      <= '0;
      changeIdeal <= 1'b0;
      ball_found  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      changeIdeal <= 1'b0;
      busy        <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (frame_end) begin
            snap_y   <= sum_y_tot;
            divisor  <= cnt_tot;
            dividend <= sum_x_tot;
            rem      <= '0;
            bit_cnt  <= '0;
            found_q  <= meets_min;
          end
        end
        DIV_X: begin
          dividend <= div_next;
          rem      <= rem_next;
          bit_cnt  <= bit_cnt + BIT_W'(1);
          if (div_done) begin
            quo_x    <= div_next[X_W-1:0];
            dividend <= snap_y;
            rem      <= '0;
            bit_cnt  <= '0;
          end
        end
        DIV_Y: begin
          dividend <= div_next;
          rem      <= rem_next;
          bit_cnt  <= bit_cnt + BIT_W'(1);
        end
        PUBLISH: begin
          if (found_q) begin
            ball_x      <= quo_x;
            ball_y      <= dividend[Y_W-1:0];
            ball_found  <= 1'b1;
            changeIdeal <= 1'b1;
          end else begin
            ball_found  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_locator.sv
// Directed bench for ball_locator: table of frames with hand-computed centroids,
// plus dropped-frame and mid-divide reset sequences.
module tb_ball_locator;

  logic       pixel_clk = 1'b0;
  logic       rst_n;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [3:0] pix_data;
  logic       frame_end;
  logic [3:0] threshold;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       changeIdeal;
  logic       ball_found;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  ball_locator dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .frame_end  (frame_end),
    .threshold  (threshold),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .changeIdeal(changeIdeal),
    .ball_found (ball_found),
    .busy       (busy)
  );

  always #20 pixel_clk = ~pixel_clk;

  typedef struct {
    int       x0, y0, w, h;
    bit [3:0] data;
    bit [3:0] thr;
    bit       oor;
    bit       fe_last;
    bit       exp_found;
    int       exp_x, exp_y;
  } frame_vec_t;

  frame_vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_px(input int x, input int y, input int d, input bit fe);
    @(negedge pixel_clk);
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 9'(y);
    pix_data  = 4'(d);
    frame_end = fe;
  endtask

  task automatic idle_inputs();
    pix_valid = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_data  = '0;
    frame_end = 1'b0;
  endtask

  task automatic send_block(input frame_vec_t v);
    int last;
    drive_px(5, 5, 0, 1'b0);
    drive_px(700, 470, 0, 1'b0);
    if (v.oor) begin
      drive_px(640, v.y0, 15, 1'b0);
      drive_px(v.x0, 480, 15, 1'b0);
      drive_px(1000, 479, 15, 1'b0);
    end
    last = v.w * v.h - 1;
    for (int j = 0; j < v.h; j++)
      for (int i = 0; i < v.w; i++)
        drive_px(v.x0 + i, v.y0 + j, v.data, v.fe_last && (j * v.w + i == last));
    if (!v.fe_last) begin
      @(negedge pixel_clk);
      idle_inputs();
      frame_end = 1'b1;
    end
  endtask

  // Called with frame_end being driven; observes the 80 cycles after its sampling edge
  task automatic wait_result(input string name, input bit exp_found, input int ex, input int ey);
    int first = -1;
    int strobes = 0;
    int busy_n = 0;
    @(negedge pixel_clk);
    idle_inputs();
    for (int k = 0; k < 80; k++) begin
      if (busy) busy_n++;
      if (changeIdeal) begin
        strobes++;
        if (first < 0) first = k;
      end
      @(negedge pixel_clk);
    end
    check({name, " strobes"}, strobes, exp_found ? 1 : 0);
    if (exp_found) check({name, " latency"}, first, 57);
    check({name, " busy_cycles"}, busy_n, exp_found ? 57 : 1);
    check({name, " ball_found"}, int'(ball_found), int'(exp_found));
    check({name, " ball_x"}, int'(ball_x), ex);
    check({name, " ball_y"}, int'(ball_y), ey);
  endtask

  task automatic run_vec(input string name, input frame_vec_t v);
    threshold = v.thr;
    send_block(v);
    wait_result(name, v.exp_found, v.exp_x, v.exp_y);
  endtask

  initial begin
    int strobes;
    int first;
    //        x0   y0   w   h  data thr oor fe_last found  ex   ey
    vecs[0] = '{100,  50,  4,  4, 15, 8, 0, 0, 1, 101,  51};
    vecs[1] = '{300, 200, 20, 20,  7, 7, 0, 0, 1, 309, 209};
    vecs[2] = '{300, 200, 20, 20,  7, 8, 0, 0, 0, 309, 209};
    vecs[3] = '{ 10,   5, 15,  1, 15, 8, 0, 0, 0, 309, 209};
    vecs[4] = '{100,  50,  4,  4, 15, 8, 1, 0, 1, 101,  51};
    vecs[5] = '{  0,   0,  4,  4, 15, 8, 0, 1, 1,   1,   1};
    vecs[6] = '{  0, 478, 17,  1,  9, 9, 0, 0, 1,   8, 478};

    rst_n = 1'b0;
    threshold = 4'd8;
    idle_inputs();
    repeat (2) @(negedge pixel_clk);
    check("reset ball_x", int'(ball_x), 0);
    check("reset ball_y", int'(ball_y), 0);
    check("reset ball_found", int'(ball_found), 0);
    check("reset changeIdeal", int'(changeIdeal), 0);
    check("reset busy", int'(busy), 0);
    rst_n = 1'b1;

    for (int n = 0; n < 7; n++) run_vec($sformatf("vec%0d", n), vecs[n]);

    // Second frame_end 10 cycles into the divide is dropped and its pixels discarded
    threshold = 4'd8;
    send_block(vecs[0]);
    @(negedge pixel_clk);
    idle_inputs();
    strobes = 0;
    first = -1;
    for (int k = 0; k < 80; k++) begin
      if (changeIdeal) begin
        strobes++;
        if (first < 0) first = k;
      end
      idle_inputs();
      if (k == 5) begin
        pix_valid = 1'b1; pix_x = 10'd590; pix_y = 9'd400; pix_data = 4'd15;
      end
      if (k == 10) begin
        pix_valid = 1'b1; pix_x = 10'd600; pix_y = 9'd400; pix_data = 4'd15;
        frame_end = 1'b1;
      end
      @(negedge pixel_clk);
    end
    check("drop strobes", strobes, 1);
    check("drop latency", first, 57);
    check("drop ball_x", int'(ball_x), 101);
    check("drop ball_y", int'(ball_y), 51);
    run_vec("after_drop", vecs[5]);

    // Reset 20 cycles into DIV_X aborts the result
    send_block('{200, 100, 4, 4, 15, 8, 0, 0, 1, 201, 101});
    @(negedge pixel_clk);
    idle_inputs();
    repeat (20) @(negedge pixel_clk);
    check("pre_abort busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort ball_x", int'(ball_x), 0);
    check("abort ball_y", int'(ball_y), 0);
    check("abort ball_found", int'(ball_found), 0);
    check("abort busy", int'(busy), 0);
    check("abort changeIdeal", int'(changeIdeal), 0);
    repeat (3) @(negedge pixel_clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int k = 0; k < 80; k++) begin
      if (changeIdeal || busy) strobes++;
      @(negedge pixel_clk);
    end
    check("abort no_activity", strobes, 0);
    run_vec("after_reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
